// File: rtl/controller_poller.sv
// Polls two NES-style shift-register controllers on a fixed period. It publishes
// per-frame button words and sticky "newly pressed" flags for the MMIO block.
module controller_poller #(
  parameter int CLK_DIV     = 4,
  parameter int NBITS       = 8,
  parameter int POLL_PERIOD = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_data1,
  input  logic             ctrl_data2,
  input  logic             new_clear,
  output logic             ctrl_latch,
  output logic             ctrl_pulse,
  output logic [NBITS-1:0] p1_buttons,
  output logic [NBITS-1:0] p2_buttons,
  output logic [NBITS-1:0] p1_new,
  output logic [NBITS-1:0] p2_new,
  output logic             frame_valid,
  output logic [2:0]       state_dbg
);

  // There is no handshake. frame_valid is a one-cycle strobe that marks the
  // edge where the button words change. new_clear is a one-cycle strobe from
  // MMIO that is honoured on the edge that samples it.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    WAIT0    = 3'd2,
    PULSE_HI = 3'd3,
    PULSE_LO = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int PW  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int PHW = $clog2(2 * CLK_DIV);
  localparam int KW  = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_PERIOD - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(CLK_DIV - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * CLK_DIV - 1);
  localparam logic [KW-1:0]  K_LAST     = KW'(NBITS - 1);

  state_t           state;
  logic [PW-1:0]    poll_cnt;
  logic [PHW-1:0]   ph;
  logic [KW-1:0]    k;
  logic [NBITS-1:0] sh1;
  logic [NBITS-1:0] sh2;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic             bit1;
  logic             bit2;
  logic [KW-1:0]    k_next;

  assign state_dbg = state;

  // The wires are active-low, so a pressed button samples as 1.
  assign bit1   = ~sync1[1];
  assign bit2   = ~sync2[1];
  assign k_next = k + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sync1[0], ctrl_data1};
      sync2 <= {sync2[0], ctrl_data2};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      poll_cnt    <= '0;
      ph          <= '0;
      k           <= '0;
      sh1         <= '0;
      sh2         <= '0;
      ctrl_latch  <= 1'b0;
      ctrl_pulse  <= 1'b0;
      p1_buttons  <= '0;
      p2_buttons  <= '0;
      p1_new      <= '0;
      p2_new      <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      // Poll counter free-runs in every state, so the LATCH period is exact.
      poll_cnt    <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
      if (new_clear) begin
        p1_new <= '0;
        p2_new <= '0;
      end
      case (state)
        IDLE: begin
          if (poll_cnt == POLL_LAST) begin
            state      <= LATCH;
            ctrl_latch <= 1'b1;
            ph         <= '0;
          end
        end
        LATCH: begin
          if (ph == LATCH_LAST) begin
            ph         <= '0;
            ctrl_latch <= 1'b0;
            state      <= WAIT0;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        WAIT0: begin
          if (ph == HALF_LAST) begin
            ph     <= '0;
            k      <= '0;
            sh1[0] <= bit1;
            sh2[0] <= bit2;
            if (NBITS == 1) begin
              state <= DONE;
            end else begin
              state      <= PULSE_HI;
              ctrl_pulse <= 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        PULSE_HI: begin
          if (ph == HALF_LAST) begin
            ph         <= '0;
            ctrl_pulse <= 1'b0;
            state      <= PULSE_LO;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        PULSE_LO: begin
          if (ph == HALF_LAST) begin
            ph          <= '0;
            k           <= k_next;
            sh1[k_next] <= bit1;
            sh2[k_next] <= bit2;
            if (k_next == K_LAST) begin
              state <= DONE;
            end else begin
              state      <= PULSE_HI;
              ctrl_pulse <= 1'b1;
            end
          end else begin
            ph <= ph + 1'b1;
          end
        end
        DONE: begin
          // A clear in this cycle drops old flags but keeps the bits set this frame.
          p1_buttons  <= sh1;
          p2_buttons  <= sh2;
          p1_new      <= (p1_new & ~{NBITS{new_clear}}) | (sh1 & ~p1_buttons);
          p2_new      <= (p2_new & ~{NBITS{new_clear}}) | (sh2 & ~p2_buttons);
          frame_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller. A behavioural pair of shift-register controllers
// feeds the DUT, and a scoreboard checks each published frame and the strobe timing.
module tb_controller_poller;

  localparam int H   = 4;
  localparam int NB  = 8;
  localparam int PP  = 200;
  localparam int FV_OFFSET = 3 * H + 2 * H * (NB - 1) + 1;  // DONE cycle 68, visible one edge later

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_data1;
  logic          ctrl_data2;
  logic          new_clear;
  logic          ctrl_latch;
  logic          ctrl_pulse;
  logic [NB-1:0] p1_buttons;
  logic [NB-1:0] p2_buttons;
  logic [NB-1:0] p1_new;
  logic [NB-1:0] p2_new;
  logic          frame_valid;
  logic [2:0]    state_dbg;

  controller_poller #(.CLK_DIV(H), .NBITS(NB), .POLL_PERIOD(PP)) dut (
    .clock       (clock),
    .reset       (reset),
    .ctrl_data1  (ctrl_data1),
    .ctrl_data2  (ctrl_data2),
    .new_clear   (new_clear),
    .ctrl_latch  (ctrl_latch),
    .ctrl_pulse  (ctrl_pulse),
    .p1_buttons  (p1_buttons),
    .p2_buttons  (p2_buttons),
    .p1_new      (p1_new),
    .p2_new      (p2_new),
    .frame_valid (frame_valid),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- counters and check ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- controller model ----------------
  // Loads the pressed word on latch rise and shifts on pulse rise. The wire is
  // active-low with idle-high fill, so pressed bits read as 0.
  logic [NB-1:0] p1_word = '0;
  logic [NB-1:0] p2_word = '0;
  logic [NB-1:0] sr1 = '0;
  logic [NB-1:0] sr2 = '0;

  always @(posedge ctrl_latch) begin
    sr1 = p1_word;
    sr2 = p2_word;
  end

  always @(posedge ctrl_pulse) begin
    sr1 = sr1 >> 1;
    sr2 = sr2 >> 1;
  end

  assign ctrl_data1 = ~sr1[0];
  assign ctrl_data2 = ~sr2[0];

  // ---------------- scoreboard ----------------
  logic [31:0]   exp_q[$];
  logic [NB-1:0] m_btn1 = '0;
  logic [NB-1:0] m_btn2 = '0;
  logic [NB-1:0] m_new1 = '0;
  logic [NB-1:0] m_new2 = '0;

  int   cyc = 0;
  int   rel_cyc = 0;
  int   latch_start = 0;
  int   last_latch = -1;
  int   latch_len = 0;
  int   pulse_len = 0;
  int   pulse_cnt = 0;
  int   frames_seen = 0;
  bit   chk_first = 1'b0;
  logic latch_q = 1'b0;
  logic pulse_q = 1'b0;

  always @(negedge clock) begin
    logic [31:0] e;
    cyc++;
    if (reset) begin
      rel_cyc    = cyc;
      chk_first  = 1'b1;
      last_latch = -1;
      latch_q    = 1'b0;
      pulse_q    = 1'b0;
      pulse_cnt  = 0;
    end else begin
      if (ctrl_latch && !latch_q) begin
        if (chk_first) check("first_latch_delay", cyc - rel_cyc, PP);
        if (last_latch >= 0) check("poll_period", cyc - last_latch, PP);
        chk_first   = 1'b0;
        last_latch  = cyc;
        latch_start = cyc;
        latch_len   = 0;
        pulse_cnt   = 0;
      end
      if (ctrl_latch) latch_len++;
      if (!ctrl_latch && latch_q) check("latch_len", latch_len, 2 * H);
      if (ctrl_pulse && !pulse_q) begin
        pulse_cnt++;
        pulse_len = 0;
      end
      if (ctrl_pulse) pulse_len++;
      if (!ctrl_pulse && pulse_q) check("pulse_len", pulse_len, H);
      if (frame_valid) begin
        frames_seen++;
        check("pulse_count", pulse_cnt, NB - 1);
        check("fv_offset", cyc - latch_start, FV_OFFSET);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("p1_buttons", p1_buttons, e[31:24]);
          check("p2_buttons", p2_buttons, e[23:16]);
          check("p1_new", p1_new, e[15:8]);
          check("p2_new", p2_new, e[7:0]);
        end
      end
      latch_q = ctrl_latch;
      pulse_q = ctrl_pulse;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Queues the expected frame, then runs one poll with the given pressed words,
  // optionally pulsing new_clear inside the DONE cycle.
  task automatic run_frame(input logic [NB-1:0] w1, input logic [NB-1:0] w2, input bit clr_in_done);
    int  start;
    bit  seen;
    p1_word = w1;
    p2_word = w2;
    m_new1  = (clr_in_done ? '0 : m_new1) | (w1 & ~m_btn1);
    m_new2  = (clr_in_done ? '0 : m_new2) | (w2 & ~m_btn2);
    m_btn1  = w1;
    m_btn2  = w2;
    exp_q.push_back({m_btn1, m_btn2, m_new1, m_new2});
    start = frames_seen;
    if (clr_in_done) begin
      seen = 1'b0;
      for (int i = 0; i < 2 * PP && !seen; i++) begin
        tick();
        if (state_dbg == 3'd5) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 0, 1);
      new_clear = 1'b1;
      tick();
      new_clear = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * PP && !seen; i++) begin
      tick();
      if (frames_seen != start) seen = 1'b1;
    end
    if (!seen) check("frame_timeout", 0, 1);
  endtask

  task automatic pulse_clear();
    new_clear = 1'b1;
    tick();
    new_clear = 1'b0;
    m_new1 = '0;
    m_new2 = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hit;
    reset     = 1'b1;
    new_clear = 1'b0;
    repeat (4) tick();
    check("rst_latch", ctrl_latch, 0);
    check("rst_pulse", ctrl_pulse, 0);
    check("rst_p1_buttons", p1_buttons, 0);
    check("rst_p2_buttons", p2_buttons, 0);
    check("rst_p1_new", p1_new, 0);
    check("rst_p2_new", p2_new, 0);
    check("rst_frame_valid", frame_valid, 0);
    reset = 1'b0;

    // Idle-high lines for three polls read as nothing pressed.
    for (int i = 0; i < 3; i++) run_frame(8'h00, 8'h00, 1'b0);

    run_frame(8'h81, 8'h5A, 1'b0);
    run_frame(8'h83, 8'h5A, 1'b0);
    pulse_clear();
    run_frame(8'h83, 8'h5A, 1'b0);

    // Clear during DONE keeps the freshly pressed bit and drops the stale flag.
    run_frame(8'h10, 8'h5A, 1'b0);
    run_frame(8'h00, 8'h5A, 1'b0);
    run_frame(8'h04, 8'h5A, 1'b1);

    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) pulse_clear();
    end

    // Reset during the high phase of the fourth shift pulse publishes nothing.
    p1_word = 8'hFF;
    p2_word = 8'hFF;
    hit = 1'b0;
    for (int i = 0; i < 3 * PP && !hit; i++) begin
      tick();
      if (pulse_cnt == 4 && ctrl_pulse) hit = 1'b1;
    end
    if (!hit) check("pulse4_timeout", 0, 1);
    reset = 1'b1;
    tick();
    check("midrst_pulse", ctrl_pulse, 0);
    check("midrst_latch", ctrl_latch, 0);
    check("midrst_p1_buttons", p1_buttons, 0);
    check("midrst_p2_buttons", p2_buttons, 0);
    check("midrst_p1_new", p1_new, 0);
    check("midrst_frame_valid", frame_valid, 0);
    reset  = 1'b0;
    m_btn1 = '0;
    m_btn2 = '0;
    m_new1 = '0;
    m_new2 = '0;
    run_frame(8'h3C, 8'hC3, 1'b0);

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controller_poller.md
# controller_poller

Serial game-controller reader that sits between the controller header on `gpio` and the memory-mapped I/O block. It periodically drives a latch/clock sequence to two NES-style shift-register controllers and shifts in both data lines in parallel. It presents debounced-by-frame parallel button words plus sticky "newly pressed" flags to `mmio`. Its `ctrl_latch`/`ctrl_pulse` outputs drive two bits of `gpioOutput`.

## Interface
- `CLK_DIV`, default 4: `clock` cycles per half-period `H` of the serial clock. Must be ≥ 4.
- `NBITS`, default 8: button bits per controller.
- `POLL_PERIOD`, default 200: `clock` cycles from one LATCH start to the next. Must be ≥ 3H + 2H(NBITS−1) + 2.
- `clock` input 1: system clock; all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `ctrl_data1` input 1: player-1 serial data. Active-low (0 = pressed). Asynchronous to `clock`.
- `ctrl_data2` input 1: player-2 serial data. Same rules as `ctrl_data1`.
- `ctrl_latch` output 1: latch strobe to both controllers.
- `ctrl_pulse` output 1: serial shift clock to both controllers.
- `p1_buttons` output NBITS: player-1 state, 1 = pressed. Bit 0 is the first bit shifted in.
- `p2_buttons` output NBITS: player-2 state, same encoding.
- `p1_new` output NBITS: sticky flags, set when the matching `p1_buttons` bit goes 0→1.
- `p2_new` output NBITS: sticky flags for player 2, same rule.
- `new_clear` input 1: one-cycle strobe from `mmio`. Clears `p1_new` and `p2_new`.
- `frame_valid` output 1: one-cycle pulse when the button outputs update.

## Operation
- Each data input passes through a 2-flop synchronizer. All sampling uses the synchronized value, inverted.
- States are IDLE, LATCH, WAIT0, PULSE_HI, PULSE_LO and DONE. Phase counter `ph` counts 0..H−1; bit index `k` counts 0..NBITS−1.
- IDLE: the poll counter counts each cycle. When it reaches POLL_PERIOD−1 it resets to 0 and the FSM moves to LATCH. The poll counter free-runs in every state, so the period is exact.
- LATCH: `ctrl_latch`=1 for 2H cycles, then → WAIT0.
- WAIT0: both outputs low for H cycles. On the last cycle, sample bit 0 into both shift registers with k=0. Then → PULSE_HI, or → DONE if NBITS=1.
- PULSE_HI: `ctrl_pulse`=1 for H cycles, then → PULSE_LO.
- PULSE_LO: `ctrl_pulse`=0 for H cycles. On the last cycle, increment k and sample into bit k. If k=NBITS−1 → DONE, else → PULSE_HI.
- DONE lasts one cycle and performs these updates:
  - `p*_buttons` ← shift registers.
  - `p*_new` ← `p*_new` | (shift & ~old `p*_buttons`).
  - `frame_valid`=1.
  - Next state → IDLE.
- `new_clear` clears the flags. If `new_clear` arrives in the DONE cycle, newly set bits survive (set wins); all other bits clear.
- A disconnected controller reads idle-high, so its word reads all-zero. This is not an error.

## Timing
- Reset values: `ctrl_latch`=0, `ctrl_pulse`=0, `p1_buttons`/`p2_buttons`=0, `p1_new`/`p2_new`=0, `frame_valid`=0. FSM in IDLE; poll counter, `ph`, `k`, shift registers and synchronizers all 0.
- First LATCH begins POLL_PERIOD cycles after `reset` deasserts.
- Transaction length, LATCH start to DONE: T = 3H + 2H(NBITS−1) cycles, with DONE in cycle T. For the defaults, T = 68.
- Outputs and `ctrl_*` are registered and change only on clock edges.
- Synchronizer delay is 2 cycles. H ≥ 4 guarantees each sampled value was launched within the same low phase.
- Reset asserted mid-transaction: the next edge returns every output to its reset value. No partial word is ever published.
- `p*_buttons` stays stable between DONE cycles.

## Test plan
- Reset, then hold both data lines high for 3 polls → `frame_valid` at cycles 200, 400 and 600 after the poll start plus 68 (DONE), buttons 0x00/0x00, and `ctrl_latch` high for exactly 8 cycles per poll.
- Controller model returns P1 bits 0x81 and P2 bits 0x5A (active-low on the wire, shifting on `ctrl_pulse` rise) → `p1_buttons`=0x81, `p2_buttons`=0x5A, `p1_new`=0x81, `p2_new`=0x5A.
- Next frame P1 = 0x83 → `p1_new`=0x83. Pulse `new_clear`, then the next frame with the same data → `p1_new`=0x00.
- Pulse `new_clear` in the DONE cycle where P1 goes 0x00→0x04, with prior `p1_new`=0x10 → `p1_new`=0x04.
- Assert `reset` for 1 cycle during PULSE_HI of bit 3 → next cycle `ctrl_pulse`=0, `ctrl_latch`=0, buttons 0. The next LATCH comes POLL_PERIOD cycles after release.
- Count `ctrl_pulse` rising edges per poll → exactly NBITS−1 = 7, each high for 4 cycles.
